// File: rtl/fs4_downconverter.sv
// fs4_downconverter: derotates a 1-bit fs/4 I,~Q,~I,Q stream and integrates-and-dumps
// N_FRAMES frames into signed I/Q samples with a one-cycle valid strobe.
module fs4_downconverter #(
    parameter int N_FRAMES = 16,
    parameter int OUT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync,
    input  logic                    data_in,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    valid_out,
    output logic [1:0]              phase_out
);
    localparam int FW = N_FRAMES > 1 ? $clog2(N_FRAMES) : 1;
    if (N_FRAMES < 1 || 2 * N_FRAMES > (1 << (OUT_W - 1)) - 1) begin : g_bad_params
        $error("fs4_downconverter: N_FRAMES/OUT_W combination can overflow");
    end
    logic [1:0]              phase;
    logic [FW-1:0]           frame;
    logic signed [OUT_W-1:0] acc_i, acc_q, nxt_i, nxt_q, x;
    logic                    dump;
    assign x         = data_in ? OUT_W'(1) : '1;
    assign dump      = phase == 2'd3 && frame == FW'(N_FRAMES - 1);
    assign phase_out = phase;
    always_comb begin
        nxt_i = acc_i + (phase == 2'd0 ? x : phase == 2'd2 ? -x : '0);
        nxt_q = acc_q + (phase == 2'd1 ? -x : phase == 2'd3 ? x : '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= 2'd0;
            frame     <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            valid_out <= 1'b0;
        end else if (sync) begin
            // realign: this sample is phase 0 of a fresh block, partial block dropped
            phase     <= 2'd1;
            frame     <= '0;
            acc_i     <= x;
            acc_q     <= '0;
            valid_out <= 1'b0;
        end else begin
            phase     <= phase + 2'd1;
            valid_out <= dump;
            if (dump) begin
                i_out <= nxt_i;
                q_out <= nxt_q;
                acc_i <= '0;
                acc_q <= '0;
                frame <= '0;
            end else begin
                acc_i <= nxt_i;
                acc_q <= nxt_q;
                if (phase == 2'd3)
                    frame <= frame + FW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fs4_downconverter.sv
// tb_fs4_downconverter: directed vectors for the fs/4 downconverter with hand-computed results.
module tb_fs4_downconverter;
    logic              clk = 1'b0;
    logic              rst_n, sync, data_in;
    logic signed [7:0] i_out, q_out;
    logic              valid_out;
    logic [1:0]        phase_out;
    int                errors = 0, checks = 0;
    int                blk = 0, hi = 0, hq = 0;

    fs4_downconverter #(.N_FRAMES(16), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .data_in(data_in),
        .i_out(i_out), .q_out(q_out), .valid_out(valid_out), .phase_out(phase_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // blk counts samples into the current block; the pattern bit is chosen by block phase
    task automatic feed(input logic [3:0] pat, input int n, input int ei, input int eq);
        for (int k = 0; k < n; k++) begin
            data_in = pat[3 - (blk % 4)];
            tick();
            blk++;
            chk("valid", valid_out, blk == 64);
            if (blk == 64) begin
                blk = 0;
                hi  = ei;
                hq  = eq;
                chk("i_dump", i_out, ei);
                chk("q_dump", q_out, eq);
            end
            chk("phase", phase_out, blk % 4);
        end
    endtask

    task automatic sync_tick(input logic d);
        sync    = 1'b1;
        data_in = d;
        tick();
        sync = 1'b0;
        blk  = 1;
        chk("sync_valid", valid_out, 0);
        chk("sync_phase", phase_out, 1);
        chk("sync_i_hold", i_out, hi);
        chk("sync_q_hold", q_out, hq);
    endtask

    task automatic reset_check();
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_phase", phase_out, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        sync    = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            data_in = i[0];
            tick();
            reset_check();
        end
        rst_n = 1'b1;
        blk   = 0;
        feed(4'b1100, 128, 32, -32);
        feed(4'b1001, 64, 32, 32);
        feed(4'b0110, 64, -32, -32);
        feed(4'b1111, 64, 0, 0);
        // loopback of an upconverted I=1,Q=1 stream, aligned by sync on its phase-0 bit
        feed(4'b1100, 10, 0, 0);
        sync_tick(1'b1);
        feed(4'b1001, 127, 32, 32);
        // sync mid-block discards the partial block
        feed(4'b1100, 20, 0, 0);
        sync_tick(1'b1);
        feed(4'b1100, 63, 32, -32);
        // sync coincident with a dump edge suppresses the dump
        feed(4'b1100, 63, 0, 0);
        sync_tick(1'b1);
        // sync held for several cycles keeps realigning
        sync_tick(1'b1);
        sync_tick(1'b1);
        feed(4'b1100, 63, 32, -32);
        // reset mid-block
        feed(4'b1100, 40, 0, 0);
        rst_n = 1'b0;
        tick();
        reset_check();
        rst_n = 1'b1;
        blk   = 0;
        hi    = 0;
        hq    = 0;
        feed(4'b1100, 64, 32, -32);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
